alu_ctrl_pipe: RTL and testbench
================================

Name: alu_ctrl_pipe

Overview:
- Pipelined, parametrised successor to the combinational ALU-control decoder.
- Decodes the full RV32I integer opcode set into an ALU control code and flags unsupported encodings as illegal.
- Carries the instruction word alongside its decode.
- Sits between the fetch/decode register and the execute stage, with a valid/ready handshake on both sides.
- Contains a one-entry skid buffer for full throughput and a saturating illegal-instruction counter.

Parameters:
- CTRL_W, 4, width of the ALU control code; must be >= 4; upper bits above bit 3 are driven 0.
- ERR_CNT_W, 8, width of the illegal-instruction counter.
- SUPPORT_SHIFTS, 1, 1 = SLL/SRL/SRA and their immediate forms decode normally; 0 = they are illegal.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, upstream instruction valid.
- in_ready, out, 1, block can accept an instruction this cycle.
- in_instr, in, 32, instruction word.
- out_valid, out, 1, decoded result valid.
- out_ready, in, 1, downstream accepts the result.
- out_ctrl, out, CTRL_W, ALU control code.
- out_illegal, out, 1, instruction not supported.
- out_instr, out, 32, instruction word passed through with its decode.
- err_clr, in, 1, synchronous clear of err_count.
- err_count, out, ERR_CNT_W, saturating count of accepted illegal instructions.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_ctrl=0, out_illegal=0, out_instr=0.
  - Skid buffer empty; err_count=0; in_ready=1.
- ALU codes (the first seven are unchanged from the previous decoder):
  - ADD=0000, SUB=0001, OR=0010, XOR=0011, AND=0100, SLT=0101, SLTU=0110.
  - SLL=0111, SRL=1000, SRA=1001, PASS_B=1010.
- Decode, keyed on opcode [6:0]:
  - 0110011, funct7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - 0110011, funct7=0100000: f3 000 SUB, 101 SRA; all other f3 illegal.
  - 0110011, any other funct7: illegal.
  - 0010011: f3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 0010011, f3 001: SLL only if [31:25]=0000000.
  - 0010011, f3 101: SRL if [31:25]=0000000, SRA if 0100000; any other [31:25] illegal.
  - 0000011 (load): f3 000/001/010/100/101 -> ADD; others illegal.
  - 0100011 (store): f3 000/001/010 -> ADD; others illegal.
  - 1100011 (branch): f3 000/001 -> SUB, 100/101 -> SLT, 110/111 -> SLTU; 010/011 illegal.
  - 0110111 (LUI) -> PASS_B.
  - 0010111 (AUIPC) and 1101111 (JAL) -> ADD.
  - 1100111 (JALR) -> ADD if f3=000, else illegal.
  - Any other opcode: illegal.
  - SUPPORT_SHIFTS=0: every SLL/SRL/SRA result above is illegal instead.
- Illegal decode: out_ctrl=ADD (0), out_illegal=1.
- Decode is purely combinational on in_instr and is registered into the pipeline.
- Latency: 1 cycle. An instruction accepted at edge N is presented with out_valid=1 after edge N, provided the output register is free.
- Handshake:
  - Accept = in_valid & in_ready. Fire = out_valid & out_ready.
  - in_ready = !skid_valid, registered and not combinationally dependent on out_ready.
  - Accept with output register empty, or with Fire in the same cycle: the decode loads the output register.
  - Accept while the output is stalled (out_valid=1 and out_ready=0): the decode loads the skid buffer and in_ready drops next cycle.
  - Fire with the skid buffer full: the output register loads from the skid, the skid empties, in_ready=1 next cycle.
  - Fire with skid empty and no Accept: out_valid=0 next cycle.
- Ordering: strictly in order; no drop, no duplication. Output payload is held stable while out_valid=1 and out_ready=0.
- err_count:
  - Increments by 1 on each Accept whose decode is illegal; counting happens at acceptance, not at output.
  - Saturates at 2^ERR_CNT_W-1.
  - err_clr=1 forces 0 next edge and has priority over a simultaneous increment.
- Reset mid-transfer discards both the output register and skid contents; nothing is replayed.

Test Plan:
- Reset, then in_valid=1 with 0x00B50533 (add), out_ready=1 -> next cycle out_valid=1, out_ctrl=0000, out_illegal=0, out_instr=0x00B50533.
- Back-to-back stream sub 0x40B50533, sra 0x40B55533, lui 0x123450B7, bltu 0x00B56463, out_ready=1 -> one result per cycle: 0001, 1001, 1010, 0110; in_ready stays 1.
- Hold out_ready=0 while sending two instructions -> second goes to skid, in_ready=0, out_* unchanged. Raise out_ready -> results drain in order, in_ready=1 the cycle after the skid empties.
- Accept 0xFFFFFFFF and 0x00002063 (branch f3 010) -> out_illegal=1, out_ctrl=0, err_count=2. Accept 300 illegal words with ERR_CNT_W=8 -> count 255. err_clr asserted with a simultaneous illegal Accept -> 0.
- SUPPORT_SHIFTS=0: accept slli 0x00151513 -> out_illegal=1. srai with [31:25]=0100001 under default parameters -> illegal.
- Assert rst_n=0 mid-cycle with skid full -> out_valid=0, in_ready=1, err_count=0 immediately (asynchronous).

Source files
------------

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: pipelined RV32I ALU-control decoder with valid/ready handshake.
//
// Decodes each accepted instruction word into an ALU control code plus an
// illegal flag, and registers both (with the instruction word) for the execute
// stage. A one-entry skid buffer absorbs the beat accepted during an output
// stall, so in_ready is a register and never depends combinationally on
// out_ready. A saturating counter tracks accepted illegal instructions.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_instr              instruction word
//   out_valid/out_ready   downstream handshake
//   out_ctrl              ALU control code (bits above 3 are zero)
//   out_illegal           instruction not supported
//   out_instr             instruction word carried with its decode
//   err_clr               synchronous clear of err_count (wins over increment)
//   err_count             saturating count of accepted illegal instructions
module alu_ctrl_pipe #(
    parameter int unsigned CTRL_W         = 4,
    parameter int unsigned ERR_CNT_W      = 8,
    parameter bit          SUPPORT_SHIFTS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic                 out_illegal,
    output logic [31:0]          out_instr,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [3:0] {
        AluAdd   = 4'b0000,
        AluSub   = 4'b0001,
        AluOr    = 4'b0010,
        AluXor   = 4'b0011,
        AluAnd   = 4'b0100,
        AluSlt   = 4'b0101,
        AluSltu  = 4'b0110,
        AluSll   = 4'b0111,
        AluSrl   = 4'b1000,
        AluSra   = 4'b1001,
        AluPassB = 4'b1010
    } alu_op_e;

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] F7Zero   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;

    // ---------------------------------------------------------------- decode
    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    alu_op_e           dec_op;
    logic              dec_bad;
    logic [CTRL_W-1:0] dec_ctrl;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    always_comb begin
        dec_op  = AluAdd;
        dec_bad = 1'b0;
        case (opc)
            OpReg: begin
                if (f7 == F7Zero) begin
                    case (f3)
                        3'b000:  dec_op = AluAdd;
                        3'b001:  dec_op = AluSll;
                        3'b010:  dec_op = AluSlt;
                        3'b011:  dec_op = AluSltu;
                        3'b100:  dec_op = AluXor;
                        3'b101:  dec_op = AluSrl;
                        3'b110:  dec_op = AluOr;
                        default: dec_op = AluAnd;
                    endcase
                end else if (f7 == F7Alt && f3 == 3'b000) begin
                    dec_op = AluSub;
                end else if (f7 == F7Alt && f3 == 3'b101) begin
                    dec_op = AluSra;
                end else begin
                    dec_bad = 1'b1;
                end
            end
            OpImm: begin
                case (f3)
                    3'b000:  dec_op = AluAdd;
                    3'b001: begin
                        if (f7 == F7Zero) dec_op = AluSll;
                        else              dec_bad = 1'b1;
                    end
                    3'b010:  dec_op = AluSlt;
                    3'b011:  dec_op = AluSltu;
                    3'b100:  dec_op = AluXor;
                    3'b101: begin
                        if (f7 == F7Zero)     dec_op = AluSrl;
                        else if (f7 == F7Alt) dec_op = AluSra;
                        else                  dec_bad = 1'b1;
                    end
                    3'b110:  dec_op = AluOr;
                    default: dec_op = AluAnd;
                endcase
            end
            // Loads: byte/half/word plus unsigned byte/half.
            OpLoad:  dec_bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            // Stores: byte/half/word only.
            OpStore: dec_bad = f3[2] || (f3 == 3'b011);
            OpBranch: begin
                case (f3[2:1])
                    2'b00:   dec_op = AluSub;
                    2'b01:   dec_bad = 1'b1;
                    2'b10:   dec_op = AluSlt;
                    default: dec_op = AluSltu;
                endcase
            end
            OpLui:          dec_op = AluPassB;
            OpAuipc, OpJal: dec_op = AluAdd;
            OpJalr:         dec_bad = (f3 != 3'b000);
            default:        dec_bad = 1'b1;
        endcase

        if (!SUPPORT_SHIFTS && (dec_op == AluSll || dec_op == AluSrl || dec_op == AluSra)) begin
            dec_bad = 1'b1;
        end
        if (dec_bad) begin
            dec_op = AluAdd;
        end

        dec_ctrl      = '0;
        dec_ctrl[3:0] = dec_op;
    end

    // -------------------------------------------------------------- pipeline
    logic              out_valid_q;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic              out_illegal_q;
    logic [31:0]       out_instr_q;
    logic              skid_valid_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              skid_illegal_q;
    logic [31:0]       skid_instr_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic              accept;

    assign in_ready    = !skid_valid_q;
    assign accept      = in_valid && !skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_ctrl    = out_ctrl_q;
    assign out_illegal = out_illegal_q;
    assign out_instr   = out_instr_q;
    assign err_count   = err_q;

    // Output register. A full skid implies out_valid_q=1, so out_ready alone
    // means Fire in that branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_ctrl_q    <= '0;
            out_illegal_q <= 1'b0;
            out_instr_q   <= '0;
        end else if (skid_valid_q) begin
            if (out_ready) begin
                out_ctrl_q    <= skid_ctrl_q;
                out_illegal_q <= skid_illegal_q;
                out_instr_q   <= skid_instr_q;
            end
        end else if (accept && (!out_valid_q || out_ready)) begin
            out_valid_q   <= 1'b1;
            out_ctrl_q    <= dec_ctrl;
            out_illegal_q <= dec_bad;
            out_instr_q   <= in_instr;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Skid buffer: catches the beat accepted while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q   <= 1'b0;
            skid_ctrl_q    <= '0;
            skid_illegal_q <= 1'b0;
            skid_instr_q   <= '0;
        end else if (accept && out_valid_q && !out_ready) begin
            skid_valid_q   <= 1'b1;
            skid_ctrl_q    <= dec_ctrl;
            skid_illegal_q <= dec_bad;
            skid_instr_q   <= in_instr;
        end else if (skid_valid_q && out_ready) begin
            skid_valid_q <= 1'b0;
        end
    end

    // Illegal counter: counted at acceptance, saturating, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (err_clr) begin
            err_q <= '0;
        end else if (accept && dec_bad && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
module tb_alu_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;
    logic        err_clr;
    logic        in_ready, out_valid, out_illegal;
    logic [3:0]  out_ctrl;
    logic [31:0] out_instr;
    logic [7:0]  err_count;
    logic        ns_in_ready, ns_out_valid, ns_out_illegal;
    logic [3:0]  ns_out_ctrl;
    logic [31:0] ns_out_instr;
    logic [7:0]  ns_err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_pipe u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_illegal (out_illegal),
        .out_instr   (out_instr),
        .err_clr     (err_clr),
        .err_count   (err_count)
    );

    // Same stimulus, shifts disabled.
    alu_ctrl_pipe #(.SUPPORT_SHIFTS(1'b0)) u_ns (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (ns_in_ready),
        .in_instr    (in_instr),
        .out_valid   (ns_out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (ns_out_ctrl),
        .out_illegal (ns_out_illegal),
        .out_instr   (ns_out_instr),
        .err_clr     (err_clr),
        .err_count   (ns_err_count)
    );

    // ------------------------------------------------------ reference model
    typedef struct {
        logic [3:0]  ctrl;
        logic        ill;
        logic [3:0]  ctrl_ns;
        logic        ill_ns;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];   // items in flight: [0] is on the output, [1] is in the skid
    int   exp_err = 0;

    // Returns -1 for illegal, otherwise the ALU code.
    function automatic int ref_code(input logic [31:0] w, input bit shifts);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int code;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        code = -1;
        if (op == 7'h33 && f7 == 7'h00) begin
            case (f3)
                0: code = 0;  1: code = 7;  2: code = 5;  3: code = 6;
                4: code = 3;  5: code = 8;  6: code = 2;  7: code = 4;
                default: code = -1;
            endcase
        end else if (op == 7'h33 && f7 == 7'h20) begin
            if (f3 == 0) code = 1;
            if (f3 == 5) code = 9;
        end else if (op == 7'h13) begin
            case (f3)
                0: code = 0;  2: code = 5;  3: code = 6;
                4: code = 3;  6: code = 2;  7: code = 4;
                1: code = (f7 == 7'h00) ? 7 : -1;
                5: code = (f7 == 7'h00) ? 8 : (f7 == 7'h20) ? 9 : -1;
                default: code = -1;
            endcase
        end else if (op == 7'h03) begin
            if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) code = 0;
        end else if (op == 7'h23) begin
            if (f3 <= 3'd2) code = 0;
        end else if (op == 7'h63) begin
            if (f3 <= 3'd1) code = 1;
            else if (f3 == 3'd4 || f3 == 3'd5) code = 5;
            else if (f3 >= 3'd6) code = 6;
        end else if (op == 7'h37) begin
            code = 10;
        end else if (op == 7'h17 || op == 7'h6F) begin
            code = 0;
        end else if (op == 7'h67) begin
            if (f3 == 0) code = 0;
        end
        if (!shifts && code >= 7 && code <= 9) code = -1;
        return code;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h67, 7'h33, 7'h13};
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 11) w[6:0] = ops[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    // One clock: drive inputs, advance the model across the posedge, return at negedge.
    task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy,
                         input logic clr);
        bit   acc, fir;
        int   c, cn;
        exp_t e;
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        err_clr   = clr;
        acc = iv && (exp_q.size() < 2);
        fir = (exp_q.size() > 0) && ordy;
        c  = ref_code(ins, 1'b1);
        cn = ref_code(ins, 1'b0);
        @(posedge clk);
        if (fir) void'(exp_q.pop_front());
        if (acc) begin
            e.ill     = (c < 0);
            e.ctrl    = (c < 0) ? 4'd0 : 4'(c);
            e.ill_ns  = (cn < 0);
            e.ctrl_ns = (cn < 0) ? 4'd0 : 4'(cn);
            e.instr   = ins;
            exp_q.push_back(e);
        end
        if (clr) exp_err = 0;
        else if (acc && c < 0 && exp_err < 255) exp_err++;
        @(negedge clk);
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b1; in_valid = 0; in_instr = 0; out_ready = 0; err_clr = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (out_ctrl !== 4'd0) begin errors++; $display("FAIL reset_out_ctrl: got %0h want 0", out_ctrl); end
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_out_illegal: got %0b want 0", out_illegal); end
        checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_out_instr: got %08h want 0", out_instr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        drive(1'b1, 32'h00B50533, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", out_valid); end
        checks++; if (out_ctrl !== 4'b0000) begin errors++; $display("FAIL add_ctrl: got %04b want 0000", out_ctrl); end
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL add_illegal: got %0b want 0", out_illegal); end
        checks++; if (out_instr !== 32'h00B50533) begin errors++; $display("FAIL add_instr: got %08h want 00B50533", out_instr); end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins  [4] = '{32'h40B50533, 32'h40B55533, 32'h123450B7, 32'h00B56463};
        logic [3:0]  want [4] = '{4'b0001, 4'b1001, 4'b1010, 4'b0110};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ins[i], 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b1 || out_ctrl !== want[i] || out_instr !== ins[i])
                begin errors++; $display("FAIL b2b_%0d: got v=%0b ctrl=%04b instr=%08h want v=1 ctrl=%04b instr=%08h",
                                         i, out_valid, out_ctrl, out_instr, want[i], ins[i]); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %0b want 1", i, in_ready); end
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h00B50533, 1'b0, 1'b0);
        drive(1'b1, 32'h40B50533, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %0b want 0", in_ready); end
        checks++; if (out_instr !== 32'h00B50533) begin errors++; $display("FAIL stall_hold: got %08h want 00B50533", out_instr); end
        drive(1'b1, 32'h123450B7, 1'b0, 1'b0);   // refused: skid full
        checks++; if (out_instr !== 32'h00B50533 || out_ctrl !== 4'b0000 || out_valid !== 1'b1)
            begin errors++; $display("FAIL stall_stable: got v=%0b instr=%08h ctrl=%04b want v=1 instr=00B50533 ctrl=0000",
                                     out_valid, out_instr, out_ctrl); end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        checks++; if (out_instr !== 32'h40B50533 || out_ctrl !== 4'b0001)
            begin errors++; $display("FAIL stall_drain2: got instr=%08h ctrl=%04b want 40B50533/0001", out_instr, out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back: got %0b want 1", in_ready); end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        drive(1'b0, 32'd0, 1'b1, 1'b1);
        drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        checks++; if (out_illegal !== 1'b1 || out_ctrl !== 4'd0)
            begin errors++; $display("FAIL ill_ffff: got ill=%0b ctrl=%04b want 1/0000", out_illegal, out_ctrl); end
        drive(1'b1, 32'h00002063, 1'b1, 1'b0);
        checks++; if (out_illegal !== 1'b1 || out_ctrl !== 4'd0)
            begin errors++; $display("FAIL ill_branch: got ill=%0b ctrl=%04b want 1/0000", out_illegal, out_ctrl); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL ill_count: got %0d want 2", err_count); end
        for (int i = 0; i < 300; i++) drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL ill_saturate: got %0d want 255", err_count); end
        drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL ill_clr_priority: got %0d want 0", err_count); end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_no_shifts();
        logic [31:0] srai_bad;
        srai_bad = {7'b0100001, 5'd3, 5'd11, 3'b101, 5'd10, 7'b0010011};
        drive(1'b1, 32'h00151513, 1'b1, 1'b0);
        checks++; if (ns_out_illegal !== 1'b1 || ns_out_ctrl !== 4'd0)
            begin errors++; $display("FAIL ns_slli: got ill=%0b ctrl=%04b want 1/0000", ns_out_illegal, ns_out_ctrl); end
        checks++; if (out_illegal !== 1'b0 || out_ctrl !== 4'b0111)
            begin errors++; $display("FAIL slli: got ill=%0b ctrl=%04b want 0/0111", out_illegal, out_ctrl); end
        drive(1'b1, srai_bad, 1'b1, 1'b0);
        checks++; if (out_illegal !== 1'b1 || out_ctrl !== 4'd0)
            begin errors++; $display("FAIL srai_bad_f7: got ill=%0b ctrl=%04b want 1/0000", out_illegal, out_ctrl); end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 40) == 0));
            checks++; if (in_ready !== (exp_q.size() < 2))
                begin errors++; $display("FAIL rnd_ready@%0d: got %0b want %0b", i, in_ready, exp_q.size() < 2); end
            checks++; if (out_valid !== (exp_q.size() > 0))
                begin errors++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, out_valid, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                checks++; if (out_ctrl !== exp_q[0].ctrl || out_illegal !== exp_q[0].ill ||
                              out_instr !== exp_q[0].instr)
                    begin errors++; $display("FAIL rnd_payload@%0d: got %04b/%0b/%08h want %04b/%0b/%08h", i,
                        out_ctrl, out_illegal, out_instr, exp_q[0].ctrl, exp_q[0].ill, exp_q[0].instr); end
                checks++; if (ns_out_ctrl !== exp_q[0].ctrl_ns || ns_out_illegal !== exp_q[0].ill_ns)
                    begin errors++; $display("FAIL rnd_ns@%0d: got %04b/%0b want %04b/%0b", i,
                        ns_out_ctrl, ns_out_illegal, exp_q[0].ctrl_ns, exp_q[0].ill_ns); end
            end
            checks++; if (err_count !== 8'(exp_err))
                begin errors++; $display("FAIL rnd_err@%0d: got %0d want %0d", i, err_count, exp_err); end
        end
    endtask

    task automatic test_async_reset();
        repeat (3) drive(1'b0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        drive(1'b1, 32'h00002063, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0 || err_count !== 8'd2)
            begin errors++; $display("FAIL arst_pre: got ready=%0b err=%0d want 0/2", in_ready, err_count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %0b want 1", in_ready); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL arst_err: got %0d want 0", err_count); end
        exp_q.delete();
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_no_replay: got %0b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_no_shifts();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
